// File: rtl/request_pending_unit_pkg.sv
// request_pending_unit_pkg: shared widths, FSM state type and one-hot clear helper
package request_pending_unit_pkg;
  localparam int REQ_W = 4;
  localparam int IDX_W = 2;
  typedef enum logic {IDLE, GRANT} state_e;
  function automatic logic [REQ_W-1:0] onehot(input logic [IDX_W-1:0] idx);
    return REQ_W'(1) << idx;
  endfunction
endpackage

// File: rtl/request_pending_unit_if.sv
// request_pending_unit_if: request, encoder feedback and grant/ack signals
interface request_pending_unit_if;
  import request_pending_unit_pkg::*;
  logic [REQ_W-1:0] R;
  logic             X;
  logic             Y;
  logic             V;
  logic [REQ_W-1:0] D;
  logic             G;
  logic [IDX_W-1:0] GI;
  logic             A;
  logic             OVF;
  logic [3:0]       CNT;
  modport master (input R, X, Y, V, A, output D, G, GI, OVF, CNT);
  modport slave  (output R, X, Y, V, A, input D, G, GI, OVF, CNT);
endinterface

// File: rtl/request_pending_unit_rise_detect.sv
// rise_detect: registers the raw lines and flags 0->1 transitions
module rise_detect #(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] R,
  output logic [width-1:0] rise
);
  logic [width-1:0] r_q;
  always_ff @(posedge clk) r_q <= rst ? '0 : R;
  assign rise = R & ~r_q;
endmodule

// File: rtl/request_pending_unit.sv
// request_pending_unit: sticky pending vector feeding the encoder, grant/ack FSM and service counter
module request_pending_unit
  import request_pending_unit_pkg::*;
#(
  parameter int HOLD_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  request_pending_unit_if.master bus
);
  logic [REQ_W-1:0] rise, clr, d_q, d_d;
  logic [IDX_W-1:0] gi_q;
  logic [3:0]       hold_q, cnt_q;
  logic             ovf_q, accept;
  state_e           state_q;
  rise_detect #(.width(REQ_W)) u_rise (.clk(clk), .rst(rst), .R(bus.R), .rise(rise));
  assign accept = (state_q == GRANT) && bus.A && (hold_q == '0);
  assign clr    = accept ? onehot(gi_q) : '0;
  // a new edge on a bit being cleared re-arms it rather than overrunning
  assign d_d    = (d_q & ~clr) | rise;
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q     <= '0;
      gi_q    <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      d_q   <= d_d;
      ovf_q <= ovf_q | (|(rise & d_q & ~clr));
      if (state_q == IDLE) begin
        if (bus.V) begin
          gi_q    <= {bus.X, bus.Y};
          hold_q  <= 4'(HOLD_CYCLES - 1);
          state_q <= GRANT;
        end
      end else if (accept) begin
        cnt_q   <= cnt_q + 4'd1;
        state_q <= IDLE;
      end else if (hold_q != '0) begin
        hold_q <= hold_q - 4'd1;
      end
    end
  end
  assign bus.D   = d_q;
  assign bus.G   = (state_q == GRANT);
  assign bus.GI  = gi_q;
  assign bus.OVF = ovf_q;
  assign bus.CNT = cnt_q;
endmodule

// File: tb/tb_request_pending_unit.sv
// tb_request_pending_unit: closes the D->encoder->X/Y/V loop and scoreboards granted indices
module tb_request_pending_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  logic g_prev = 1'b0;
  logic [1:0] exp_q[$];
  request_pending_unit_if bus ();
  request_pending_unit #(.HOLD_CYCLES(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  // 4-line priority encoder, bit 3 highest
  assign bus.X = bus.D[3] | bus.D[2];
  assign bus.Y = bus.D[3] | (~bus.D[2] & bus.D[1]);
  assign bus.V = |bus.D;
  always #5 clk = ~clk;

  task automatic tick();
    logic [1:0] e;
    @(posedge clk);
    #1;
    if (bus.G && !g_prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL grant_unexpected GI=%b expected no grant", bus.GI);
      end else begin
        e = exp_q.pop_front();
        if (bus.GI !== e) begin
          errors++;
          $display("FAIL grant_index got=%b exp=%b", bus.GI, e);
        end
      end
    end
    g_prev = bus.G;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.R = 4'b0000; bus.A = 1'b0;
    tick(); tick();
    checks++; if (bus.D !== 4'b0000) begin errors++; $display("FAIL reset_d got=%b exp=0000", bus.D); end
    checks++; if (bus.G !== 1'b0) begin errors++; $display("FAIL reset_g got=%b exp=0", bus.G); end
    checks++; if (bus.GI !== 2'b00) begin errors++; $display("FAIL reset_gi got=%b exp=00", bus.GI); end
    checks++; if (bus.OVF !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus.OVF); end
    checks++; if (bus.CNT !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", bus.CNT); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    exp_q.push_back(2'b10);
    bus.R = 4'b0100; bus.A = 1'b1;
    tick();
    checks++; if (bus.D !== 4'b0100) begin errors++; $display("FAIL single_d got=%b exp=0100", bus.D); end
    checks++; if (bus.G !== 1'b0) begin errors++; $display("FAIL single_g_early got=%b exp=0", bus.G); end
    tick();
    checks++; if (bus.G !== 1'b1) begin errors++; $display("FAIL single_g1 got=%b exp=1", bus.G); end
    tick();
    checks++; if (bus.G !== 1'b1) begin errors++; $display("FAIL single_g2 got=%b exp=1", bus.G); end
    tick();
    checks++; if (bus.G !== 1'b0) begin errors++; $display("FAIL single_g_end got=%b exp=0", bus.G); end
    checks++; if (bus.D !== 4'b0000) begin errors++; $display("FAIL single_d_clr got=%b exp=0000", bus.D); end
    checks++; if (bus.CNT !== 4'd1) begin errors++; $display("FAIL single_cnt got=%0d exp=1", bus.CNT); end
    bus.R = 4'b0000;
    tick();
  endtask

  task automatic test_two_same();
    exp_q.push_back(2'b11); exp_q.push_back(2'b00);
    bus.R = 4'b1001; bus.A = 1'b1;
    tick(); tick(); tick(); tick();
    checks++; if (bus.D !== 4'b0001) begin errors++; $display("FAIL two_d_mid got=%b exp=0001", bus.D); end
    checks++; if (bus.G !== 1'b0) begin errors++; $display("FAIL two_gap got=%b exp=0", bus.G); end
    tick(); tick(); tick();
    checks++; if (bus.D !== 4'b0000) begin errors++; $display("FAIL two_d_end got=%b exp=0000", bus.D); end
    checks++; if (bus.CNT !== 4'd3) begin errors++; $display("FAIL two_cnt got=%0d exp=3", bus.CNT); end
    bus.R = 4'b0000;
    tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL two_queue got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_no_preempt();
    exp_q.push_back(2'b01); exp_q.push_back(2'b11);
    bus.R = 4'b0010; bus.A = 1'b0;
    tick(); tick();
    bus.R = 4'b1010;
    tick();
    checks++; if (bus.D !== 4'b1010) begin errors++; $display("FAIL preempt_d got=%b exp=1010", bus.D); end
    checks++; if (bus.GI !== 2'b01) begin errors++; $display("FAIL preempt_gi got=%b exp=01", bus.GI); end
    tick(); tick();
    checks++; if (bus.G !== 1'b1 || bus.GI !== 2'b01) begin errors++; $display("FAIL preempt_hold got=%b/%b exp=1/01", bus.G, bus.GI); end
    bus.A = 1'b1;
    tick();
    checks++; if (bus.D !== 4'b1000) begin errors++; $display("FAIL preempt_d_clr got=%b exp=1000", bus.D); end
    checks++; if (bus.CNT !== 4'd4) begin errors++; $display("FAIL preempt_cnt got=%0d exp=4", bus.CNT); end
    tick(); tick(); tick();
    checks++; if (bus.CNT !== 4'd5) begin errors++; $display("FAIL preempt_cnt2 got=%0d exp=5", bus.CNT); end
    bus.R = 4'b0000; bus.A = 1'b0;
    tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL preempt_queue got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_overrun();
    exp_q.push_back(2'b10);
    bus.R = 4'b0100; bus.A = 1'b0;
    tick();
    checks++; if (bus.OVF !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", bus.OVF); end
    tick();
    bus.R = 4'b0000;
    tick();
    bus.R = 4'b0100;
    tick();
    checks++; if (bus.OVF !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", bus.OVF); end
    checks++; if (bus.D !== 4'b0100) begin errors++; $display("FAIL ovf_d got=%b exp=0100", bus.D); end
    bus.R = 4'b0000;
    tick();
    bus.A = 1'b1;
    tick();
    checks++; if (bus.OVF !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", bus.OVF); end
    checks++; if (bus.CNT !== 4'd6) begin errors++; $display("FAIL ovf_cnt got=%0d exp=6", bus.CNT); end
    bus.A = 1'b0; rst = 1'b1;
    tick();
    checks++; if (bus.OVF !== 1'b0) begin errors++; $display("FAIL ovf_rst got=%b exp=0", bus.OVF); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_set_wins();
    exp_q.push_back(2'b10); exp_q.push_back(2'b10);
    bus.R = 4'b0100; bus.A = 1'b0;
    tick(); tick(); tick();
    bus.R = 4'b0000;
    tick();
    bus.R = 4'b0100; bus.A = 1'b1;
    tick();
    checks++; if (bus.D !== 4'b0100) begin errors++; $display("FAIL setwin_d got=%b exp=0100", bus.D); end
    checks++; if (bus.OVF !== 1'b0) begin errors++; $display("FAIL setwin_ovf got=%b exp=0", bus.OVF); end
    checks++; if (bus.CNT !== 4'd1) begin errors++; $display("FAIL setwin_cnt got=%0d exp=1", bus.CNT); end
    checks++; if (bus.G !== 1'b0) begin errors++; $display("FAIL setwin_gap got=%b exp=0", bus.G); end
    tick(); tick(); tick();
    checks++; if (bus.D !== 4'b0000 || bus.CNT !== 4'd2) begin errors++; $display("FAIL setwin_end got=%b/%0d exp=0000/2", bus.D, bus.CNT); end
    bus.R = 4'b0000; bus.A = 1'b0;
    tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL setwin_queue got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_rst_mid_grant();
    exp_q.push_back(2'b11);
    bus.R = 4'b1000; bus.A = 1'b0;
    tick(); tick();
    bus.R = 4'b0000;
    tick();
    bus.R = 4'b1000;
    tick();
    checks++; if (bus.G !== 1'b1 || bus.OVF !== 1'b1) begin errors++; $display("FAIL midrst_pre got=%b/%b exp=1/1", bus.G, bus.OVF); end
    rst = 1'b1; bus.R = 4'b0000;
    tick();
    checks++; if (bus.G !== 1'b0) begin errors++; $display("FAIL midrst_g got=%b exp=0", bus.G); end
    checks++; if (bus.D !== 4'b0000) begin errors++; $display("FAIL midrst_d got=%b exp=0000", bus.D); end
    checks++; if (bus.CNT !== 4'd0) begin errors++; $display("FAIL midrst_cnt got=%0d exp=0", bus.CNT); end
    checks++; if (bus.OVF !== 1'b0) begin errors++; $display("FAIL midrst_ovf got=%b exp=0", bus.OVF); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    bus.A = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(2'b00);
      bus.R = 4'b0001;
      tick();
      bus.R = 4'b0000;
      tick(); tick(); tick();
      if (i == 14) begin
        checks++; if (bus.CNT !== 4'd15) begin errors++; $display("FAIL wrap_cnt15 got=%0d exp=15", bus.CNT); end
      end
    end
    checks++; if (bus.CNT !== 4'd0) begin errors++; $display("FAIL wrap_cnt0 got=%0d exp=0", bus.CNT); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_queue got=%0d exp=0", exp_q.size()); end
    bus.A = 1'b0;
    tick();
  endtask

  initial begin
    bus.R = 4'b0000;
    bus.A = 1'b0;
    test_reset();
    test_single();
    test_two_same();
    test_no_preempt();
    test_overrun();
    test_set_wins();
    test_rst_mid_grant();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/request_pending_unit.md
# request_pending_unit

Upstream stage of the 4-line priority encoder (inputs D, outputs X, Y, V). It captures rising edges on four raw request lines into a sticky pending vector and drives that vector as the encoder's D. It takes the encoder's X/Y/V back and grants the highest-priority pending request to a consumer over a grant/acknowledge handshake. On acknowledge it clears the serviced bit and counts completed services.

## Interface
- HOLD_CYCLES, default 2: minimum number of cycles G stays high before A is honoured; legal range 1..15.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- R  in  4  raw request lines, synchronous to clk; a request is a 0→1 transition.
- X  in  1  encoder code MSB.
- Y  in  1  encoder code LSB.
- V  in  1  encoder valid (any D bit set).
- D  out  4  pending vector, wired to encoder D; bit 3 highest priority.
- G  out  1  grant valid to consumer.
- GI  out  2  granted index {X,Y} captured at grant; stable while G=1.
- A  in  1  consumer acknowledge; sampled only while G=1.
- OVF  out  1  sticky overrun flag.
- CNT  out  4  completed-service count, modulo 16.

## Operation
- Edge detect: register r_q <= R; rise = R & ~r_q.
- Pending update each cycle: D <= (D & ~clr) | rise. clr is a one-hot mask of GI when an acknowledge is accepted, otherwise 0. When rise and clr hit the same bit, set wins: the bit stays pending and OVF is not set.
- OVF: set when rise[i]=1, D[i]=1 and bit i is not being cleared this cycle. It clears only on rst.
- State machine, 2 states:
  - IDLE: G=0. If V=1, capture GI <= {X,Y}, load hold counter with HOLD_CYCLES-1, and go to GRANT. If V=0, X and Y are ignored.
  - GRANT: G=1. The hold counter decrements to 0 and saturates. An acknowledge is accepted when A=1 and the counter is 0; on acceptance: clr = onehot(GI), CNT <= CNT+1, go to IDLE. A=1 while the counter is nonzero is ignored; it is not remembered.
- No preemption: a higher-priority rise during GRANT only sets its D bit. GI does not change.
- CNT wraps 15→0 silently.
- Reset values: D=0000, G=0, GI=00, OVF=0, CNT=0000, r_q=0000, state IDLE, hold counter 0.
- r_q resets to 0, so a line already high when reset releases counts as an edge in the first cycle after reset.
- rst asserted mid-grant: everything returns to reset values on that edge. The pending grant is dropped without counting.

## Timing
- Rise on R sampled at edge n sets D at edge n. V becomes valid combinationally in cycle n+1, G=1 from edge n+1, so grant latency is 1 cycle after D sets.
- Minimum grant length is HOLD_CYCLES cycles. With A held high, G falls exactly HOLD_CYCLES cycles after it rose.
- After acceptance, state is IDLE for at least 1 cycle, so back-to-back grants are separated by one G=0 cycle. The next grant uses the post-clear D.
- X/Y/V are combinational from D (the encoder has no register). The D→encoder→FSM path is same-cycle, and the FSM samples it at the next edge.

## Structure
- Shared package holds:
  - REQ_W=4 and IDX_W=2;
  - the state enum {IDLE, GRANT};
  - the onehot(index) function used for clr.
- Sub-module rise_detect (parameter width, ports clk, rst, R, rise) is natural; rest stays in the top.
- The bench instantiates this block together with the existing encoder, closing the D→X/Y/V loop.

## Test plan
- Reset then R=0000→0100, A held 1, HOLD_CYCLES=2 → D=0100 next edge; G=1, GI=10 one cycle later, for 2 cycles; then D=0000, CNT=1, G=0.
- R rises 0001 and 1000 same cycle, A=1 → first grant GI=11, D→0001; after one idle cycle second grant GI=00, D→0000, CNT=2.
- Grant on GI=01, then R bit 3 rises during GRANT → GI stays 01 until ack; next grant GI=11.
- R bit 2 pulses 0→1→0→1 while D[2]=1 and no ack → OVF=1, stays 1 until rst; D=0100 unchanged.
- Ack accepted on GI=10 in the same cycle R bit 2 rises → D[2] stays 1, OVF=0, CNT increments, new grant GI=10 after one idle cycle.
- 16 serviced requests → CNT wraps to 0000. rst asserted while G=1 → next cycle G=0, D=0000, CNT=0000, OVF=0.
